// File: rtl/gpio_port.sv
// gpio_port: memory-mapped GPIO block with data/direction registers, a
// synchronised pin input and an optional rising-edge interrupt unit.
// Optional feature macro: GPIO_IRQ_EN (adds IMASK/ISTAT, edge detection,
// startup arming and the IRQ output; without it IRQ is tied low).
module gpio_port #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       addr,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    input  logic [WIDTH-1:0] pad_in,
    output logic [WIDTH-1:0] pad_out,
    output logic [WIDTH-1:0] pad_oe,
    output logic             irq
);

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_DIR      = 3'd1;
    localparam logic [2:0] ADDR_PIN      = 3'd2;
    localparam logic [2:0] ADDR_IMASK    = 3'd3;
    localparam logic [2:0] ADDR_ISTAT    = 3'd4;
    localparam logic [2:0] ADDR_DATA_SET = 3'd5;
    localparam logic [2:0] ADDR_DATA_CLR = 3'd6;

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] dir_q;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] pin;
    logic [WIDTH-1:0] rd_data;

    logic wr_data;
    logic wr_dir;
    logic wr_set;
    logic wr_clr;

    assign wr_data = wr_en && (addr == ADDR_DATA);
    assign wr_dir  = wr_en && (addr == ADDR_DIR);
    assign wr_set  = wr_en && (addr == ADDR_DATA_SET);
    assign wr_clr  = wr_en && (addr == ADDR_DATA_CLR);

    assign pin     = sync_q[SYNC_STAGES-1];
    assign pad_out = data_q;
    assign pad_oe  = dir_q;

    // Output data register with direct, set and clear write ports
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (wr_data) begin
            data_q <= data_in;
        end else if (wr_set) begin
            data_q <= data_q | data_in;
        end else if (wr_clr) begin
            data_q <= data_q & ~data_in;
        end
    end

    // Direction register, 1 = pin driven
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_q <= '0;
        end else if (wr_dir) begin
            dir_q <= data_in;
        end
    end

    // Per-bit metastability chain on the asynchronous pad inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= pad_in;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

`ifdef GPIO_IRQ_EN
    typedef enum logic {
        ARMING = 1'b0,
        RUN    = 1'b1
    } state_t;

    localparam int unsigned CNT_W = 3;

    state_t           state;
    logic [CNT_W-1:0] arm_cnt;
    logic [WIDTH-1:0] pin_prev;
    logic [WIDTH-1:0] imask_q;
    logic [WIDTH-1:0] istat_q;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] w1c_mask;

    // Edges only count on inputs, and only once the sync chain has settled
    assign edge_hit = (state == RUN) ? (pin & ~pin_prev & ~dir_q) : '0;
    assign w1c_mask = (wr_en && (addr == ADDR_ISTAT)) ? data_in : '0;

    // Startup sequencer: hold off detection for SYNC_STAGES+1 cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ARMING;
            arm_cnt <= '0;
        end else begin
            case (state)
                ARMING: begin
                    if (arm_cnt == CNT_W'(SYNC_STAGES)) begin
                        state <= RUN;
                    end else begin
                        arm_cnt <= arm_cnt + CNT_W'(1);
                    end
                end
                RUN:     state <= RUN;
                default: state <= ARMING;
            endcase
        end
    end

    // Pin history always tracks, so a DIR 1->0 change sees no stale edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pin_prev <= '0;
        end else begin
            pin_prev <= pin;
        end
    end

    // Interrupt mask register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imask_q <= '0;
        end else if (wr_en && (addr == ADDR_IMASK)) begin
            imask_q <= data_in;
        end
    end

    // Interrupt status: W1C, with a same-cycle edge winning over the clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            istat_q <= '0;
        end else begin
            istat_q <= (istat_q & ~w1c_mask) | edge_hit;
        end
    end

    // Level interrupt from any unmasked pending status bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq <= 1'b0;
        end else begin
            irq <= |(istat_q & imask_q);
        end
    end
`else
    assign irq = 1'b0;
`endif

    // Read mux over current register contents (pre-write on simultaneous access)
    always_comb begin
        rd_data = '0;
        case (addr)
            ADDR_DATA:  rd_data = data_q;
            ADDR_DIR:   rd_data = dir_q;
            ADDR_PIN:   rd_data = pin;
`ifdef GPIO_IRQ_EN
            ADDR_IMASK: rd_data = imask_q;
            ADDR_ISTAT: rd_data = istat_q;
`endif
            default:    rd_data = '0;
        endcase
    end

    // Registered read data, held until the next read strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= '0;
        end else if (rd_en) begin
            data_out <= rd_data;
        end
    end

endmodule

// File: tb/tb_gpio_port.sv
// tb_gpio_port: directed self-checking bench for gpio_port.
// Interrupt scenarios follow the GPIO_IRQ_EN macro used for the build.
module tb_gpio_port;

    localparam int unsigned W = 8;
    localparam int unsigned S = 2;

    logic         clk;
    logic         rst_n;
    logic [2:0]   addr;
    logic         wr_en;
    logic         rd_en;
    logic [W-1:0] data_in;
    logic [W-1:0] data_out;
    logic [W-1:0] pad_in;
    logic [W-1:0] pad_out;
    logic [W-1:0] pad_oe;
    logic         irq;

    int checks;
    int fails;

    gpio_port #(.WIDTH(W), .SYNC_STAGES(S)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .addr     (addr),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .data_in  (data_in),
        .data_out (data_out),
        .pad_in   (pad_in),
        .pad_out  (pad_out),
        .pad_oe   (pad_oe),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic write_reg(input logic [2:0] a, input logic [W-1:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        addr    = a;
        data_in = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic read_reg(input logic [2:0] a);
        @(negedge clk);
        rd_en = 1'b1;
        addr  = a;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        addr    = 3'd0;
        data_in = '0;
        pad_in  = '0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (pad_out !== 8'h00) begin fails++; $display("FAIL reset_pad_out got=%h exp=00", pad_out); end
        checks++; if (pad_oe !== 8'h00) begin fails++; $display("FAIL reset_pad_oe got=%h exp=00", pad_oe); end
        checks++; if (data_out !== 8'h00) begin fails++; $display("FAIL reset_data_out got=%h exp=00", data_out); end
        checks++; if (irq !== 1'b0) begin fails++; $display("FAIL reset_irq got=%b exp=0", irq); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_data_dir();
        write_reg(3'd1, 8'hF0);
        write_reg(3'd0, 8'hA5);
        checks++; if (pad_oe !== 8'hF0) begin fails++; $display("FAIL dir_pad_oe got=%h exp=f0", pad_oe); end
        checks++; if (pad_out !== 8'hA5) begin fails++; $display("FAIL data_pad_out got=%h exp=a5", pad_out); end
        read_reg(3'd1);
        checks++; if (data_out !== 8'hF0) begin fails++; $display("FAIL read_dir got=%h exp=f0", data_out); end
        @(negedge clk);
        rd_en = 1'b1;
        addr  = 3'd0;
        #1;
        checks++; if (data_out !== 8'hF0) begin fails++; $display("FAIL read_latency got=%h exp=f0", data_out); end
        @(negedge clk);
        rd_en = 1'b0;
        checks++; if (data_out !== 8'hA5) begin fails++; $display("FAIL read_data got=%h exp=a5", data_out); end
        repeat (2) @(negedge clk);
        checks++; if (data_out !== 8'hA5) begin fails++; $display("FAIL read_hold got=%h exp=a5", data_out); end
    endtask

    task automatic test_set_clr();
        write_reg(3'd0, 8'h0F);
        write_reg(3'd5, 8'h30);
        checks++; if (pad_out !== 8'h3F) begin fails++; $display("FAIL data_set got=%h exp=3f", pad_out); end
        write_reg(3'd6, 8'h01);
        checks++; if (pad_out !== 8'h3E) begin fails++; $display("FAIL data_clr got=%h exp=3e", pad_out); end
        read_reg(3'd0);
        checks++; if (data_out !== 8'h3E) begin fails++; $display("FAIL read_set_clr got=%h exp=3e", data_out); end
        read_reg(3'd5);
        checks++; if (data_out !== 8'h00) begin fails++; $display("FAIL read_addr5 got=%h exp=00", data_out); end
        read_reg(3'd0);
        read_reg(3'd6);
        checks++; if (data_out !== 8'h00) begin fails++; $display("FAIL read_addr6 got=%h exp=00", data_out); end
        write_reg(3'd7, 8'hFF);
        read_reg(3'd0);
        read_reg(3'd7);
        checks++; if (data_out !== 8'h00) begin fails++; $display("FAIL read_addr7 got=%h exp=00", data_out); end
        checks++; if (pad_out !== 8'h3E || pad_oe !== 8'hF0) begin
            fails++; $display("FAIL addr7_ignored got=%h/%h exp=3e/f0", pad_out, pad_oe);
        end
    endtask

    task automatic test_rd_wr_same();
        @(negedge clk);
        wr_en   = 1'b1;
        rd_en   = 1'b1;
        addr    = 3'd0;
        data_in = 8'h77;
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        checks++; if (data_out !== 8'h3E) begin fails++; $display("FAIL rdwr_pre_value got=%h exp=3e", data_out); end
        checks++; if (pad_out !== 8'h77) begin fails++; $display("FAIL rdwr_write got=%h exp=77", pad_out); end
    endtask

    task automatic test_pin();
        @(negedge clk);
        pad_in = 8'h5A;
        rd_en  = 1'b1;
        addr   = 3'd2;
        repeat (S) @(negedge clk);
        checks++; if (data_out !== 8'h00) begin fails++; $display("FAIL pin_sync_delay got=%h exp=00", data_out); end
        @(negedge clk);
        rd_en = 1'b0;
        checks++; if (data_out !== 8'h5A) begin fails++; $display("FAIL pin_value got=%h exp=5a", data_out); end
    endtask

`ifdef GPIO_IRQ_EN
    task automatic test_edge_irq();
        bit seen;
        pad_in = '0;
        do_reset();
        repeat (10) @(negedge clk);
        write_reg(3'd1, 8'h00);
        write_reg(3'd3, 8'h01);
        pad_in = 8'h01;
        seen = 1'b0;
        for (int i = 0; i < int'(S) + 2; i++) begin
            @(negedge clk);
            if (irq === 1'b1) seen = 1'b1;
        end
        checks++; if (!seen) begin fails++; $display("FAIL edge_irq_timeout got=0 exp=1 within %0d cycles", S + 2); end
        read_reg(3'd4);
        checks++; if (data_out !== 8'h01) begin fails++; $display("FAIL edge_istat got=%h exp=01", data_out); end
        write_reg(3'd4, 8'h01);
        checks++; if (irq !== 1'b1) begin fails++; $display("FAIL w1c_irq_lag got=%b exp=1", irq); end
        @(negedge clk);
        checks++; if (irq !== 1'b0) begin fails++; $display("FAIL w1c_irq_clear got=%b exp=0", irq); end
    endtask

    task automatic test_arming();
        bit bad;
        pad_in = 8'hFF;
        do_reset();
        write_reg(3'd3, 8'hFF);
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (irq !== 1'b0) bad = 1'b1;
        end
        checks++; if (bad) begin fails++; $display("FAIL arming_irq got=1 exp=0"); end
        read_reg(3'd4);
        checks++; if (data_out !== 8'h00) begin fails++; $display("FAIL arming_istat got=%h exp=00", data_out); end
    endtask

    task automatic test_w1c_dir();
        pad_in = 8'h00;
        repeat (5) @(negedge clk);
        @(negedge clk);
        pad_in = 8'h04;
        repeat (S) @(negedge clk);
        wr_en   = 1'b1;
        addr    = 3'd4;
        data_in = 8'h04;
        @(negedge clk);
        wr_en = 1'b0;
        read_reg(3'd4);
        checks++; if (data_out !== 8'h04) begin fails++; $display("FAIL edge_beats_w1c got=%h exp=04", data_out); end
        write_reg(3'd4, 8'h04);
        read_reg(3'd4);
        checks++; if (data_out !== 8'h00) begin fails++; $display("FAIL w1c_clear got=%h exp=00", data_out); end
        write_reg(3'd1, 8'h04);
        pad_in = 8'h00;
        repeat (5) @(negedge clk);
        pad_in = 8'h04;
        repeat (5) @(negedge clk);
        read_reg(3'd4);
        checks++; if (data_out !== 8'h00) begin fails++; $display("FAIL output_pin_edge got=%h exp=00", data_out); end
        write_reg(3'd1, 8'h00);
        repeat (5) @(negedge clk);
        read_reg(3'd4);
        checks++; if (data_out !== 8'h00) begin fails++; $display("FAIL dir_release_edge got=%h exp=00", data_out); end
        pad_in = 8'h00;
        repeat (5) @(negedge clk);
        pad_in = 8'h04;
        repeat (5) @(negedge clk);
        read_reg(3'd4);
        checks++; if (data_out !== 8'h04) begin fails++; $display("FAIL edge_after_release got=%h exp=04", data_out); end
        write_reg(3'd4, 8'hFF);
        write_reg(3'd3, 8'h00);
        pad_in = 8'h06;
        repeat (5) @(negedge clk);
        read_reg(3'd4);
        checks++; if (data_out !== 8'h02) begin fails++; $display("FAIL masked_latch got=%h exp=02", data_out); end
        checks++; if (irq !== 1'b0) begin fails++; $display("FAIL masked_irq got=%b exp=0", irq); end
    endtask
`else
    task automatic test_irq_disabled();
        bit bad;
        pad_in = '0;
        do_reset();
        repeat (10) @(negedge clk);
        write_reg(3'd1, 8'h00);
        write_reg(3'd3, 8'h01);
        read_reg(3'd3);
        checks++; if (data_out !== 8'h00) begin fails++; $display("FAIL noirq_imask_read got=%h exp=00", data_out); end
        pad_in = 8'h01;
        bad = 1'b0;
        for (int i = 0; i < int'(S) + 4; i++) begin
            @(negedge clk);
            if (irq !== 1'b0) bad = 1'b1;
        end
        checks++; if (bad) begin fails++; $display("FAIL noirq_irq got=1 exp=0"); end
        read_reg(3'd2);
        checks++; if (data_out !== 8'h01) begin fails++; $display("FAIL noirq_pin got=%h exp=01", data_out); end
        read_reg(3'd4);
        checks++; if (data_out !== 8'h00) begin fails++; $display("FAIL noirq_istat_read got=%h exp=00", data_out); end
    endtask
`endif

    task automatic test_reset_mid_read();
        write_reg(3'd0, 8'h55);
        write_reg(3'd1, 8'hFF);
        read_reg(3'd0);
        checks++; if (data_out !== 8'h55) begin fails++; $display("FAIL pre_reset_read got=%h exp=55", data_out); end
        @(negedge clk);
        rd_en = 1'b1;
        addr  = 3'd0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (data_out !== 8'h00) begin fails++; $display("FAIL async_data_out got=%h exp=00", data_out); end
        checks++; if (pad_out !== 8'h00) begin fails++; $display("FAIL async_pad_out got=%h exp=00", pad_out); end
        checks++; if (pad_oe !== 8'h00) begin fails++; $display("FAIL async_pad_oe got=%h exp=00", pad_oe); end
        checks++; if (irq !== 1'b0) begin fails++; $display("FAIL async_irq got=%b exp=0", irq); end
        rd_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (data_out !== 8'h00) begin fails++; $display("FAIL read_discarded got=%h exp=00", data_out); end
        read_reg(3'd0);
        checks++; if (data_out !== 8'h00) begin fails++; $display("FAIL data_after_reset got=%h exp=00", data_out); end
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        test_reset();
        test_data_dir();
        test_set_clr();
        test_rd_wr_same();
        test_pin();
`ifdef GPIO_IRQ_EN
        test_edge_irq();
        test_arming();
        test_w1c_dir();
`else
        test_irq_disabled();
`endif
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
